// File: rtl/lbs_arb.sv
// Two-master round-robin arbiter and sequencer for the lbs_* local register bus.
// One transaction at a time: grant in IDLE, strobe in ISSUE, wait out read latency, ack.
module lbs_arb #(
  parameter int U_DLY  = 1,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [15:0] lbs_addr,
  output logic [31:0] lbs_din,
  output logic        lbs_we,
  output logic        lbs_re,
  input  logic [31:0] lbs_dout,
  output logic        grant,
  output logic        busy
);

  // U_DLY only matters to legacy delayed-assignment simulation; registers here are zero-delay.
  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1 + 0 * U_DLY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t      state_q, state_d;
  logic        dir_q, dir_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      addr_q       <= 16'd0;
      din_q        <= 32'd0;
      rdata0_q     <= 32'd0;
      rdata1_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    din_d        = din_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    sel          = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master that was not served last wins.
          sel          = (m0_req && m1_req) ? ~last_grant_q : m1_req;
          addr_d       = sel ? m1_addr : m0_addr;
          dir_d        = sel ? m1_we : m0_we;
          if (dir_d) din_d = sel ? m1_wdata : m0_wdata;
          grant_d      = sel;
          last_grant_d = sel;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (dir_q) begin
          state_d = ACK;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (grant_q) rdata1_d = lbs_dout;
          else         rdata0_d = lbs_dout;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lbs_we = 1'b0;
    lbs_re = 1'b0;
    m0_ack = 1'b0;
    m1_ack = 1'b0;
    busy   = (state_q != IDLE);
    case (state_q)
      ISSUE: begin
        lbs_we = dir_q;
        lbs_re = ~dir_q;
      end
      ACK: begin
        m0_ack = ~grant_q;
        m1_ack = grant_q;
      end
      default: ;
    endcase
  end

  assign lbs_addr = addr_q;
  assign lbs_din  = din_q;
  assign grant    = grant_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_lbs_arb.sv
// Bench for lbs_arb: directed scenarios with literal expectations plus a
// transaction-level model checked every cycle, and a latency-exact slave.
module tb_lbs_arb;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [15:0] m0_addr = 16'd0, m1_addr = 16'd0;
  logic [31:0] m0_wdata = 32'd0, m1_wdata = 32'd0, lbs_dout = 32'd0;
  logic        m0_ack, m1_ack, lbs_we, lbs_re, grant, busy;
  logic [31:0] m0_rdata, m1_rdata, lbs_din;
  logic [15:0] lbs_addr;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit          re_hist [64];
  logic [15:0] addr_hist [64];

  // Model state: one in-flight transaction described by its start cycle.
  bit          m_active = 1'b0, m_last = 1'b1, t_m = 1'b0, t_we = 1'b0;
  logic [15:0] t_addr = 16'd0;
  logic [31:0] t_wdata = 32'd0;
  int          t_start = 0, t_ackk = 0, mk = 0;
  logic        e_busy, e_we, e_re, e_ack0, e_ack1, e_grant;
  logic [15:0] e_addr = 16'd0;
  logic [31:0] e_din = 32'd0, e_rd0 = 32'd0, e_rd1 = 32'd0;

  bit ack_seen0 = 1'b0, ack_seen1 = 1'b0;
  bit exp_grant_seq [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  lbs_arb #(.U_DLY(1), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .lbs_addr(lbs_addr), .lbs_din(lbs_din), .lbs_we(lbs_we), .lbs_re(lbs_re),
    .lbs_dout(lbs_dout), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] slave_data(input logic [15:0] a);
    return (a == 16'h0004) ? 32'hDEADBEEF : {~a, a};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit m, input bit we, input logic [15:0] a, input logic [31:0] d);
    if (!m) begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else    begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic dropReq(input bit m);
    if (!m) m0_req = 1'b0;
    else    m1_req = 1'b0;
  endtask

  task automatic waitAck(input bit m, input int budget);
    bit got = 1'b0;
    for (int n = 0; n < budget && !got; n++) begin
      sample();
      got = m ? m1_ack : m0_ack;
      if (!got) step();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL ack_timeout m%0d: actual=no ack required=ack within %0d cycles", m, budget);
    end
  endtask

  // Requests are scrambled while pending; only the grant-cycle values may matter.
  task automatic randDrive(input bit m, input bit acked, input bit allow_new);
    bit pending;
    pending = m ? m1_req : m0_req;
    if (acked) dropReq(m);
    else if (pending) begin
      if ($urandom_range(1, 0) == 1) applyStimulus(m, 1'($urandom), 16'($urandom), $urandom);
    end else if (allow_new && $urandom_range(2, 0) == 0)
      applyStimulus(m, 1'($urandom), 16'($urandom), $urandom);
  endtask

  // Slave: read data appears exactly RD_LAT cycles after the lbs_re cycle, junk otherwise.
  always @(negedge clk) begin
    re_hist[cyc % 64]   = lbs_re;
    addr_hist[cyc % 64] = lbs_addr;
  end

  always @(posedge clk) begin
    #1;
    if (cyc >= RD_LAT && re_hist[(cyc - RD_LAT) % 64])
      lbs_dout = slave_data(addr_hist[(cyc - RD_LAT) % 64]);
    else
      lbs_dout = 32'hBAD0_0000 | 32'(cyc[15:0]);
  end

  always @(negedge clk) begin
    e_we = 1'b0; e_re = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0; m_last = 1'b1; e_busy = 1'b0; e_grant = 1'b0;
      e_addr = 16'd0; e_din = 32'd0; e_rd0 = 32'd0; e_rd1 = 32'd0;
    end else begin
      if (m_active && (cyc - t_start) > t_ackk) m_active = 1'b0;
      if (!m_active) begin
        e_busy = 1'b0;
        if (m0_req || m1_req) begin
          t_m     = (m0_req && m1_req) ? !m_last : m1_req;
          t_we    = t_m ? m1_we : m0_we;
          t_addr  = t_m ? m1_addr : m0_addr;
          t_wdata = t_m ? m1_wdata : m0_wdata;
          t_start = cyc;
          t_ackk  = t_we ? 2 : 2 + RD_LAT;
          m_last  = t_m;
          m_active = 1'b1;
        end
      end else begin
        mk = cyc - t_start;
        e_busy = 1'b1;
        if (mk == 1) begin
          e_we = t_we; e_re = !t_we; e_addr = t_addr; e_grant = t_m;
          if (t_we) e_din = t_wdata;
        end
        if (mk == t_ackk) begin
          if (t_m) e_ack1 = 1'b1; else e_ack0 = 1'b1;
          if (!t_we) begin
            if (t_m) e_rd1 = slave_data(t_addr); else e_rd0 = slave_data(t_addr);
          end
        end
      end
    end
    checkOutput("busy", 32'(busy), 32'(e_busy));
    checkOutput("lbs_we", 32'(lbs_we), 32'(e_we));
    checkOutput("lbs_re", 32'(lbs_re), 32'(e_re));
    checkOutput("m0_ack", 32'(m0_ack), 32'(e_ack0));
    checkOutput("m1_ack", 32'(m1_ack), 32'(e_ack1));
    checkOutput("grant", 32'(grant), 32'(e_grant));
    checkOutput("lbs_addr", 32'(lbs_addr), 32'(e_addr));
    checkOutput("lbs_din", lbs_din, e_din);
    checkOutput("m0_rdata", m0_rdata, e_rd0);
    checkOutput("m1_rdata", m1_rdata, e_rd1);
    checks++;
    if (lbs_we && lbs_re) begin
      errors++;
      $display("[TB] FAIL we_re_exclusive at cycle %0d: actual=both high required=at most one", cyc);
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) begin step(); sample(); end
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_addr", 32'(lbs_addr), 32'd0);
    checkOutput("rst_m0_rdata", m0_rdata, 32'd0);
    step(); rst_n = 1'b1; sample();

    // m0 write
    step(); applyStimulus(1'b0, 1'b1, 16'h0010, 32'hA5A5_0001); sample();
    checkOutput("t1_idle_busy", 32'(busy), 32'd0);
    step(); sample();
    checkOutput("t1_we", 32'(lbs_we), 32'd1);
    checkOutput("t1_addr", 32'(lbs_addr), 32'h0010);
    checkOutput("t1_din", lbs_din, 32'hA5A5_0001);
    checkOutput("t1_m0_ack_early", 32'(m0_ack), 32'd0);
    step(); sample();
    checkOutput("t1_m0_ack", 32'(m0_ack), 32'd1);
    checkOutput("t1_m1_ack", 32'(m1_ack), 32'd0);

    // m1 read, RD_LAT=2
    step(); dropReq(1'b0); applyStimulus(1'b1, 1'b0, 16'h0004, 32'd0); sample();
    step(); sample();
    checkOutput("t2_re", 32'(lbs_re), 32'd1);
    checkOutput("t2_addr", 32'(lbs_addr), 32'h0004);
    checkOutput("t2_din_held", lbs_din, 32'hA5A5_0001);
    step(); sample();
    step(); sample();
    checkOutput("t2_m1_ack_early", 32'(m1_ack), 32'd0);
    step(); sample();
    checkOutput("t2_m1_ack", 32'(m1_ack), 32'd1);
    checkOutput("t2_m1_rdata", m1_rdata, 32'hDEADBEEF);
    checkOutput("t2_m0_rdata", m0_rdata, 32'd0);

    // both masters held continuously from reset
    step(); dropReq(1'b1); rst_n = 1'b0; sample();
    step(); sample();
    step(); rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'h0100, 32'h0000_0100);
    applyStimulus(1'b1, 1'b1, 16'h0200, 32'h0000_0200);
    sample();
    for (int n = 0; n < 6; n++) begin
      step(); sample();
      checkOutput("t3_grant", 32'(grant), 32'(exp_grant_seq[n]));
      checkOutput("t3_we", 32'(lbs_we), 32'd1);
      step(); sample();
      checkOutput("t3_m0_ack", 32'(m0_ack), 32'(!exp_grant_seq[n]));
      checkOutput("t3_m1_ack", 32'(m1_ack), 32'(exp_grant_seq[n]));
      step();
      if (n == 5) begin dropReq(1'b0); dropReq(1'b1); end
      sample();
    end

    // m1 arrives while m0 read waits; m0 re-requests immediately after its ack
    step(); applyStimulus(1'b0, 1'b0, 16'h0030, 32'd0); sample();
    step(); sample();
    checkOutput("t4_grant_a", 32'(grant), 32'd0);
    checkOutput("t4_re_a", 32'(lbs_re), 32'd1);
    step(); applyStimulus(1'b1, 1'b1, 16'h0040, 32'h1111_2222); sample();
    step(); sample();
    checkOutput("t4_m0_ack_early", 32'(m0_ack), 32'd0);
    step(); sample();
    checkOutput("t4_m0_ack", 32'(m0_ack), 32'd1);
    checkOutput("t4_m0_rdata", m0_rdata, 32'hFFCF_0030);
    step(); sample();
    step(); sample();
    checkOutput("t4_grant_b", 32'(grant), 32'd1);
    checkOutput("t4_addr_b", 32'(lbs_addr), 32'h0040);
    checkOutput("t4_din_b", lbs_din, 32'h1111_2222);
    step(); sample();
    checkOutput("t4_m1_ack", 32'(m1_ack), 32'd1);
    step(); dropReq(1'b1); sample();
    step(); sample();
    checkOutput("t4_grant_c", 32'(grant), 32'd0);
    checkOutput("t4_re_c", 32'(lbs_re), 32'd1);
    repeat (3) begin step(); sample(); end
    checkOutput("t4_m0_ack2", 32'(m0_ack), 32'd1);

    // reset during WAIT of a read
    step(); dropReq(1'b0); sample();
    step(); applyStimulus(1'b0, 1'b0, 16'h0050, 32'd0); sample();
    step(); sample();
    checkOutput("t5_re", 32'(lbs_re), 32'd1);
    step(); rst_n = 1'b0; dropReq(1'b0); sample();
    checkOutput("t5_rst_re", 32'(lbs_re), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_grant", 32'(grant), 32'd0);
    repeat (2) begin
      step(); sample();
      checkOutput("t5_rst_m0_ack", 32'(m0_ack), 32'd0);
    end
    step(); rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0004, 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0060, 32'd0);
    sample();
    step(); sample();
    checkOutput("t5_grant", 32'(grant), 32'd0);
    checkOutput("t5_addr", 32'(lbs_addr), 32'h0004);
    repeat (3) begin step(); sample(); end
    checkOutput("t5_m0_ack", 32'(m0_ack), 32'd1);
    checkOutput("t5_m0_rdata", m0_rdata, 32'hDEADBEEF);
    step(); dropReq(1'b0);
    waitAck(1'b1, 20);
    checkOutput("t5_m1_rdata", m1_rdata, 32'hFF9F_0060);
    step(); dropReq(1'b1); sample();

    // random mixed traffic, then drain
    for (int i = 0; i < 500; i++) begin
      step();
      randDrive(1'b0, ack_seen0, 1'b1);
      randDrive(1'b1, ack_seen1, 1'b1);
      sample();
      ack_seen0 = m0_ack;
      ack_seen1 = m1_ack;
    end
    for (int i = 0; i < 40; i++) begin
      step();
      randDrive(1'b0, ack_seen0, 1'b0);
      randDrive(1'b1, ack_seen1, 1'b0);
      sample();
      ack_seen0 = m0_ack;
      ack_seen1 = m1_ack;
    end
    checkOutput("drain_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
